hlsm_launcher: RTL and testbench

HLSM_LAUNCHER -- requirements
Module: hlsm_launcher

---
 rtl/hlsm_pkg.sv | 19 +
 rtl/hlsm_cycle_counter.sv | 33 +++
 rtl/hlsm_launcher.sv | 115 +++++++++++
 tb/tb_hlsm_launcher.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/hlsm_pkg.sv
// rtl/hlsm_pkg.sv - shared state encoding and default constants for the HLSM launcher
package hlsm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } hlsm_state_t;

    localparam int DATA_W_DEF  = 16;
    localparam int TIMEOUT_DEF = 64;
    localparam int MIN_RUN_DEF = 2;

    // Bits needed to hold every count value from 0 up to and including limit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/hlsm_cycle_counter.sv
// rtl/hlsm_cycle_counter.sv - run-length counter that saturates at LIMIT and flags MIN/LIMIT
module hlsm_cycle_counter
    import hlsm_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEF,
    parameter int MIN   = MIN_RUN_DEF
) (
    input  logic Clk,
    input  logic Rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_at_min,
    output logic o_at_limit
);

    localparam int            CW      = cnt_width(LIMIT);
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);
    localparam logic [CW-1:0] MIN_C   = CW'(MIN);

    logic [CW-1:0] r_count;

    always_ff @(posedge Clk) begin
        if (Rst || i_clear) begin
            r_count <= '0;
        end else if (i_en && (r_count != LIMIT_C)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_at_min   = (r_count >= MIN_C);
    assign o_at_limit = (r_count == LIMIT_C);

endmodule

// File: rtl/hlsm_launcher.sv
// rtl/hlsm_launcher.sv - accepts one operand set, runs the HLSM datapath, returns result or timeout
module hlsm_launcher
    import hlsm_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int MIN_RUN = MIN_RUN_DEF
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_a,
    input  logic signed [DATA_W-1:0] in_b,
    input  logic signed [DATA_W-1:0] in_c,
    input  logic signed [DATA_W-1:0] in_d,
    input  logic signed [DATA_W-1:0] in_e,
    output logic                     Start,
    output logic signed [DATA_W-1:0] a,
    output logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] c,
    output logic signed [DATA_W-1:0] d,
    output logic signed [DATA_W-1:0] e,
    input  logic signed [DATA_W-1:0] i,
    input  logic                     Done,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic                     out_err
);

    hlsm_state_t r_state;
    hlsm_state_t w_state_next;

    logic signed [DATA_W-1:0] r_a, r_b, r_c, r_d, r_e;
    logic signed [DATA_W-1:0] r_out_data;
    logic                     r_out_err;

    logic w_accept;
    logic w_at_min;
    logic w_at_limit;
    logic w_done_q;
    logic w_timeout;
    logic w_finish;

    hlsm_cycle_counter #(
        .LIMIT (TIMEOUT),
        .MIN   (MIN_RUN)
    ) u_cycle_counter (
        .Clk        (Clk),
        .Rst        (Rst),
        .i_clear    (w_accept),
        .i_en       (r_state == RUN),
        .o_at_min   (w_at_min),
        .o_at_limit (w_at_limit)
    );

    assign w_accept  = (r_state == IDLE) && in_valid;
    // Early Done is a leftover level from the previous run, so it only counts past MIN_RUN.
    assign w_done_q  = (r_state == RUN) && Done && w_at_min;
    assign w_timeout = (r_state == RUN) && w_at_limit;
    assign w_finish  = w_done_q || w_timeout;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_c        <= '0;
            r_d        <= '0;
            r_e        <= '0;
            r_out_data <= '0;
            r_out_err  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_a <= in_a;
                r_b <= in_b;
                r_c <= in_c;
                r_d <= in_d;
                r_e <= in_e;
            end
            if (w_done_q) begin
                r_out_data <= i;
                r_out_err  <= 1'b0;
            end else if (w_timeout) begin
                r_out_data <= '0;
                r_out_err  <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid)  w_state_next = RUN;
            RUN:     if (w_finish)  w_state_next = HOLD;
            HOLD:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Start falls in the finishing cycle itself so it is never seen alongside a captured result.
    assign Start     = (r_state == RUN) && !w_finish;
    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == HOLD);
    assign out_data  = r_out_data;
    assign out_err   = r_out_err;
    assign a         = r_a;
    assign b         = r_b;
    assign c         = r_c;
    assign d         = r_d;
    assign e         = r_e;

endmodule

// File: tb/tb_hlsm_launcher.sv
// tb/tb_hlsm_launcher.sv - self-checking bench: vector table, hand sequences, randomized ops vs model
module tb_hlsm_launcher;

    localparam int DW = 16;
    localparam int TO = 64;
    localparam int MR = 2;
    localparam int STALE_I = -99;

    logic                 Clk = 1'b0;
    logic                 Rst;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_a, in_b, in_c, in_d, in_e;
    logic                 Start;
    logic signed [DW-1:0] a, b, c, d, e;
    logic signed [DW-1:0] i;
    logic                 Done;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] out_data;
    logic                 out_err;

    int n_tests = 0;
    int n_fail  = 0;
    int nx[5] = '{11, 12, 13, 14, 15};

    always #5 Clk = ~Clk;

    hlsm_launcher #(.DATA_W(DW), .TIMEOUT(TO), .MIN_RUN(MR)) dut (
        .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d), .in_e(in_e),
        .Start(Start), .a(a), .b(b), .c(c), .d(d), .e(e),
        .i(i), .Done(Done), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err)
    );

    typedef struct {
        int a, b, c, d, e;
        int done_at;
        bit stale;
        int res;
        int bp;
        int exp_fin;
        int exp_err;
        int exp_data;
    } vec_t;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Reference: Done counts from max(done_at, MR); a run never outlasts TO cycles, Done wins a tie.
    function automatic int eff_done(input int done_at);
        if (done_at < 0) return 1_000_000;
        return (done_at < MR) ? MR : done_at;
    endfunction

    function automatic int model_fin(input int done_at);
        return (eff_done(done_at) <= TO) ? eff_done(done_at) : TO;
    endfunction

    function automatic int model_err(input int done_at);
        return (eff_done(done_at) > TO) ? 1 : 0;
    endfunction

    task automatic chk_ops(input string tag, input int va, vb, vc, vd, ve);
        chk({tag, " a"}, a, va);
        chk({tag, " b"}, b, vb);
        chk({tag, " c"}, c, vc);
        chk({tag, " d"}, d, vd);
        chk({tag, " e"}, e, ve);
    endtask

    task automatic do_op(input string tag, input int va, vb, vc, vd, ve,
                         input int done_at, input bit stale, input int res, input int bp,
                         input bit keep_valid, input int exp_fin, input int exp_err,
                         input int exp_data);
        int fin;
        fin = -1;
        in_valid = 1'b1;
        in_a = va[DW-1:0]; in_b = vb[DW-1:0]; in_c = vc[DW-1:0];
        in_d = vd[DW-1:0]; in_e = ve[DW-1:0];
        #1;
        chk({tag, " in_ready_idle"}, in_ready, 1);
        chk({tag, " start_idle"}, Start, 0);
        step();
        if (keep_valid) begin
            in_a = nx[0][DW-1:0]; in_b = nx[1][DW-1:0]; in_c = nx[2][DW-1:0];
            in_d = nx[3][DW-1:0]; in_e = nx[4][DW-1:0];
        end else begin
            in_valid = 1'b0;
        end
        for (int k = 0; k <= TO + 4; k++) begin
            if (done_at >= 0 && k >= done_at) begin
                Done = 1'b1;
                i = res[DW-1:0];
            end else if (stale && k < MR) begin
                Done = 1'b1;
                i = STALE_I[DW-1:0];
            end else begin
                Done = 1'b0;
                i = STALE_I[DW-1:0];
            end
            #1;
            if (k == 0) chk_ops({tag, " run_ops"}, va, vb, vc, vd, ve);
            chk({tag, " in_ready_run"}, in_ready, 0);
            chk({tag, " out_valid_run"}, out_valid, 0);
            if (Start === 1'b0) begin
                fin = k;
                break;
            end
            step();
        end
        chk({tag, " start_cycles"}, fin, exp_fin);
        chk_ops({tag, " end_ops"}, va, vb, vc, vd, ve);
        step();
        out_ready = 1'b0;
        for (int h = 0; h <= bp; h++) begin
            #1;
            chk({tag, " hold_valid"}, out_valid, 1);
            chk({tag, " hold_data"}, out_data, exp_data);
            chk({tag, " hold_err"}, out_err, exp_err);
            chk({tag, " hold_in_ready"}, in_ready, 0);
            chk({tag, " hold_start"}, Start, 0);
            if (h < bp) step();
        end
        chk_ops({tag, " hold_ops"}, va, vb, vc, vd, ve);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        #1;
        chk({tag, " post_valid"}, out_valid, 0);
        chk({tag, " post_in_ready"}, in_ready, 1);
        chk_ops({tag, " post_ops"}, va, vb, vc, vd, ve);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        tbl[0] = '{a: 5,     b: -3,     c: 1,   d: 2,    e: 3,  done_at: 12, stale: 0, res: 2,      bp: 0,  exp_fin: 12, exp_err: 0, exp_data: 2};
        tbl[1] = '{a: 4,     b: 3,      c: 0,   d: 0,    e: 0,  done_at: 12, stale: 1, res: 7,      bp: 0,  exp_fin: 12, exp_err: 0, exp_data: 7};
        tbl[2] = '{a: 9,     b: 9,      c: 9,   d: 9,    e: 9,  done_at: -1, stale: 0, res: 55,     bp: 0,  exp_fin: 64, exp_err: 1, exp_data: 0};
        tbl[3] = '{a: -7,    b: 8,      c: 100, d: -100, e: 0,  done_at: 20, stale: 0, res: -321,   bp: 10, exp_fin: 20, exp_err: 0, exp_data: -321};
        tbl[4] = '{a: 1,     b: 2,      c: 3,   d: 4,    e: 5,  done_at: 0,  stale: 0, res: 11,     bp: 0,  exp_fin: 2,  exp_err: 0, exp_data: 11};
        tbl[5] = '{a: -1,    b: -2,     c: -3,  d: -4,   e: -5, done_at: 64, stale: 1, res: 1234,   bp: 1,  exp_fin: 64, exp_err: 0, exp_data: 1234};
        tbl[6] = '{a: 0,     b: 0,      c: 0,   d: 0,    e: 1,  done_at: 65, stale: 0, res: 77,     bp: 2,  exp_fin: 64, exp_err: 1, exp_data: 0};
        tbl[7] = '{a: 32767, b: -32768, c: 0,   d: 1,    e: -1, done_at: 2,  stale: 1, res: -32768, bp: 1,  exp_fin: 2,  exp_err: 0, exp_data: -32768};

        Rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; Done = 1'b0; i = '0;
        in_a = '0; in_b = '0; in_c = '0; in_d = '0; in_e = '0;
        step();
        step();
        #1;
        chk("reset in_ready", in_ready, 1);
        chk("reset start", Start, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_err", out_err, 0);
        chk("reset out_data", out_data, 0);
        chk_ops("reset", 0, 0, 0, 0, 0);
        Rst = 1'b0;

        for (int t = 0; t < 8; t++) begin
            do_op($sformatf("vec%0d", t), tbl[t].a, tbl[t].b, tbl[t].c, tbl[t].d, tbl[t].e,
                  tbl[t].done_at, tbl[t].stale, tbl[t].res, tbl[t].bp, 1'b0,
                  tbl[t].exp_fin, tbl[t].exp_err, tbl[t].exp_data);
        end

        // Reset in RUN cycle 5 discards the operation.
        in_valid = 1'b1;
        in_a = 16'sd3; in_b = 16'sd4; in_c = 16'sd5; in_d = 16'sd6; in_e = 16'sd7;
        step();
        in_valid = 1'b0;
        Done = 1'b0;
        for (int k = 0; k < 5; k++) step();
        Rst = 1'b1;
        step();
        Rst = 1'b0;
        #1;
        chk("midrst start", Start, 0);
        chk("midrst out_valid", out_valid, 0);
        chk("midrst in_ready", in_ready, 1);
        chk("midrst out_err", out_err, 0);
        chk("midrst out_data", out_data, 0);
        chk_ops("midrst", 0, 0, 0, 0, 0);
        do_op("after_rst", 1, 1, 0, 0, 0, 12, 0, 2, 0, 1'b0, 12, 0, 2);

        // Back-to-back: second set held valid throughout the first operation.
        do_op("b2b_first", 21, 22, 23, 24, 25, 5, 1, 100, 3, 1'b1, 5, 0, 100);
        do_op("b2b_second", nx[0], nx[1], nx[2], nx[3], nx[4], 7, 1, -200, 0, 1'b0, 7, 0, -200);

        for (int r = 0; r < 24; r++) begin
            int ra, rb, rc, rd, re, rdone, rres, rbp;
            bit rstale;
            ra = int'($urandom_range(0, 65535)) - 32768;
            rb = int'($urandom_range(0, 65535)) - 32768;
            rc = int'($urandom_range(0, 65535)) - 32768;
            rd = int'($urandom_range(0, 65535)) - 32768;
            re = int'($urandom_range(0, 65535)) - 32768;
            rres = int'($urandom_range(0, 65535)) - 32768;
            rdone = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 70));
            rstale = 1'($urandom_range(0, 1));
            rbp = int'($urandom_range(0, 3));
            do_op($sformatf("rnd%0d", r), ra, rb, rc, rd, re, rdone, rstale, rres, rbp, 1'b0,
                  model_fin(rdone), model_err(rdone),
                  (model_err(rdone) != 0) ? 0 : rres);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
